logic_gate_pipe: RTL and testbench

Parametrised, registered successor to the two-input multiple-gate block. It applies one of eight bitwise gate functions to two WIDTH-bit operands per beat, behind a valid/ready handshake with a registered output. It can also fold a multi-beat chain of operands through an internal accumulator and emit only the final result. Reduction flags and a beat count are provided with every result, for use wherever a selectable, flow-controlled logic stage is needed.

---
 rtl/logic_gate_pipe.sv | 123 ++++++++++++
 tb/tb_logic_gate_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// Selectable bitwise gate stage behind a valid/ready handshake with a one-entry
// registered output, optionally folding a multi-beat operand chain through an accumulator.
//
// state | meaning
// IDLE  | no chain open; a beat emits a result or opens a chain
// CHAIN | acc holds a partial fold; beats combine in_a with acc until in_last
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHAIN = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOT_A  = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_NOR    = 3'd3;
    localparam logic [2:0] OP_NAND   = 3'd4;
    localparam logic [2:0] OP_XOR    = 3'd5;
    localparam logic [2:0] OP_XNOR   = 3'd6;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             load_out;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] gate_val;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_NOT_A: r = ~a;
            OP_OR:    r = a | b;
            OP_AND:   r = a & b;
            OP_NOR:   r = ~(a | b);
            OP_NAND:  r = ~(a & b);
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            default:  r = a;
        endcase
        return r;
    endfunction

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        operand_b = in_b;
        cnt_next  = CNT_W'(1);
        load_out  = 1'b0;
        if (state == CHAIN) begin
            // Chain beats fold onto the accumulator; in_b is only the seed.
            operand_b = acc;
            cnt_next  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
            load_out  = accept & in_last;
        end else begin
            load_out  = accept & (~in_acc | in_last);
        end
        gate_val = gate_fn(in_op, in_a, operand_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= 3'd0;
            out_count  <= '0;
            out_zero   <= 1'b0;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
        end else begin
            if (load_out) begin
                state      <= IDLE;
                out_valid  <= 1'b1;
                out_result <= gate_val;
                out_op     <= in_op;
                out_count  <= cnt_next;
                out_zero   <= ~|gate_val;
                out_ones   <= &gate_val;
                out_parity <= ^gate_val;
            end else begin
                if (accept) begin
                    state <= CHAIN;
                    acc   <= gate_val;
                    cnt   <= cnt_next;
                end
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized and directed bench for logic_gate_pipe; two instances (CNT_W=8 and
// CNT_W=2) share stimulus and are compared against a truth-table reference model.
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       in_acc = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready,   in_ready2;
    logic       out_valid,  out_valid2;
    logic [7:0] out_result, out_result2;
    logic [2:0] out_op,     out_op2;
    logic [7:0] out_count;
    logic [1:0] out_count2;
    logic       out_zero, out_ones, out_parity;
    logic       out_zero2, out_ones2, out_parity2;

    int n_checks = 0;
    int n_errors = 0;
    bit checking_on = 1'b0;
    bit rnd_ready = 1'b0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_op(out_op), .out_count(out_count), .out_zero(out_zero),
        .out_ones(out_ones), .out_parity(out_parity)
    );

    logic_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_op(out_op2), .out_count(out_count2), .out_zero(out_zero2),
        .out_ones(out_ones2), .out_parity(out_parity2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each gate as a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] gate_ref(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [3:0] tt;
        logic [7:0] r;
        case (op)
            3'd0:    tt = 4'b0011;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b1000;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b0110;
            3'd6:    tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // Reference model: transaction-level view of the pipe.
    bit         m_valid, m_chain, m_take, m_emit;
    logic [7:0] m_acc, m_result, m_v;
    logic [2:0] m_op;
    int         m_count, m_cnt, m_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_chain = 0; m_acc = '0; m_cnt = 0;
            m_result = '0; m_op = '0; m_count = 0;
        end else begin
            m_take = in_valid && (!m_valid || out_ready);
            m_emit = 0;
            if (m_take) begin
                if (m_chain) begin
                    m_v = gate_ref(in_op, in_a, m_acc);
                    m_n = m_cnt + 1;
                    if (in_last) m_emit = 1;
                    else begin m_acc = m_v; m_cnt = m_n; end
                end else begin
                    m_v = gate_ref(in_op, in_a, in_b);
                    m_n = 1;
                    if (in_acc && !in_last) begin
                        m_chain = 1; m_acc = m_v; m_cnt = 1;
                    end else m_emit = 1;
                end
            end
            if (m_emit) begin
                m_valid = 1; m_result = m_v; m_op = in_op; m_count = m_n; m_chain = 0;
            end else if (out_ready) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (checking_on) begin
            check_val("ready",   in_ready,   !m_valid || out_ready);
            check_val("ready2",  in_ready2,  !m_valid || out_ready);
            check_val("valid",   out_valid,  m_valid);
            check_val("valid2",  out_valid2, m_valid);
            if (m_valid) begin
                check_val("result",  out_result,  m_result);
                check_val("result2", out_result2, m_result);
                check_val("op",      out_op,      m_op);
                check_val("count",   out_count,   (m_count > 255) ? 255 : m_count);
                check_val("count2",  out_count2,  (m_count > 3) ? 3 : m_count);
                check_val("zero",    out_zero,    m_result == 8'h00);
                check_val("ones",    out_ones,    m_result == 8'hFF);
                check_val("parity",  out_parity,  $countones(m_result) % 2);
                check_val("parity2", out_parity2, $countones(m_result) % 2);
            end
        end
    end

    // Present one beat and hold it until accepted; returns cycles spent.
    task automatic beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic last, output int cyc);
        bit done;
        done = 0;
        cyc = 0;
        in_valid = 1; in_op = op; in_a = a; in_b = b; in_acc = acc; in_last = last;
        while (!done && cyc < 50) begin
            @(negedge clk);
            done = !m_valid || out_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (rnd_ready) out_ready = ($urandom % 4) != 0;
        end
        in_valid = 0;
        if (!done) check_val("accept_timeout", 0, 1);
    endtask

    logic [7:0] ops_exp [8] = '{8'h5A, 8'hBD, 8'h24, 8'h42, 8'hDB, 8'h99, 8'h66, 8'hA5};

    initial begin
        int cyc;
        logic [7:0] exp_v;
        #12;
        check_val("rst_valid",  out_valid,  0);
        check_val("rst_result", out_result, 0);
        check_val("rst_ready",  in_ready,   1);
        @(negedge clk);
        rst_n = 1;
        checking_on = 1;
        @(posedge clk); #1;

        for (int op = 0; op < 8; op++) begin
            beat(3'(op), 8'hA5, 8'h3C, 0, 0, cyc);
            exp_v = ops_exp[op];
            check_val("ops_cycles", cyc, 1);
            check_val("ops_valid",  out_valid,  1);
            check_val("ops_result", out_result, exp_v);
            check_val("ops_count",  out_count,  1);
            check_val("ops_parity", out_parity, $countones(exp_v) % 2);
        end

        @(posedge clk); #1;
        out_ready = 0;
        beat(3'd2, 8'hF0, 8'h3C, 0, 0, cyc);
        in_valid = 1; in_op = 3'd1; in_a = 8'h01; in_b = 8'h02; in_acc = 0; in_last = 0;
        repeat (5) begin
            @(negedge clk);
            check_val("bp_ready",  in_ready,   0);
            check_val("bp_valid",  out_valid,  1);
            check_val("bp_hold",   out_result, 8'h30);
        end
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        check_val("bp_reload_valid",  out_valid,  1);
        check_val("bp_reload_result", out_result, 8'h03);

        @(posedge clk); #1;
        beat(3'd5, 8'h01, 8'h00, 1, 0, cyc);
        check_val("chain_nv1", out_valid, 0);
        beat(3'd5, 8'h02, 8'h00, 1, 0, cyc);
        check_val("chain_nv2", out_valid, 0);
        beat(3'd5, 8'h04, 8'h00, 1, 1, cyc);
        check_val("chain_valid",  out_valid,  1);
        check_val("chain_result", out_result, 8'h07);
        check_val("chain_count",  out_count,  3);
        check_val("chain_zero",   out_zero,   0);
        check_val("chain_parity", out_parity, 1);

        beat(3'd1, 8'h01, 8'h00, 1, 0, cyc);
        beat(3'd1, 8'h02, 8'h00, 0, 0, cyc);
        beat(3'd1, 8'h04, 8'h00, 0, 0, cyc);
        beat(3'd1, 8'h08, 8'h00, 0, 0, cyc);
        beat(3'd1, 8'h10, 8'h00, 0, 1, cyc);
        check_val("sat_result2", out_result2, 8'h1F);
        check_val("sat_count2",  out_count2,  3);
        check_val("sat_count",   out_count,   5);

        beat(3'd2, 8'hFF, 8'h00, 0, 0, cyc);
        check_val("flag_and_result", out_result, 8'h00);
        check_val("flag_zero",       out_zero,   1);
        beat(3'd6, 8'h5A, 8'h5A, 0, 0, cyc);
        check_val("flag_xnor_result", out_result, 8'hFF);
        check_val("flag_ones",        out_ones,   1);

        beat(3'd1, 8'h0F, 8'h30, 1, 0, cyc);
        beat(3'd2, 8'hFF, 8'h00, 0, 0, cyc);
        #3;
        rst_n = 0;
        #1;
        check_val("mrst_valid",  out_valid,  0);
        check_val("mrst_result", out_result, 0);
        check_val("mrst_op",     out_op,     0);
        check_val("mrst_count",  out_count,  0);
        check_val("mrst_flags",  {out_zero, out_ones, out_parity}, 0);
        check_val("mrst_ready",  in_ready,   1);
        @(negedge clk);
        rst_n = 1;
        beat(3'd5, 8'h0F, 8'hF0, 0, 0, cyc);
        check_val("post_rst_result", out_result, 8'hFF);
        check_val("post_rst_count",  out_count,  1);

        rnd_ready = 1;
        repeat (400) begin
            if ($urandom % 5 == 0) begin
                @(posedge clk); #1;
                out_ready = ($urandom % 4) != 0;
            end
            beat(3'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom % 3) == 0, ($urandom % 3) == 0, cyc);
        end
        beat(3'd0, 8'h00, 8'h00, 0, 1, cyc);
        rnd_ready = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
